// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result bundle between a requesting controller and the
// nibble-serial adder sequencer.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  // Sequencer side.
  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built by time-sharing one 4-bit ripple-carry adder,
// one nibble per clock, least significant nibble first.

// 4-bit ripple-carry adder shared by all nibble positions.
module fourBit_FA (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [4:0] c;

  // Ripple the carry through four full-adder stages.
  always_comb begin
    c[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             sub_q,   sub_d;

  logic [3:0] a_nib;
  logic [3:0] b_eff;
  logic [3:0] fa_s;
  logic       fa_cout;

  // Current nibble of the latched operands; B is inverted for subtract.
  always_comb begin
    a_nib = a_q[4*idx_q +: 4];
    b_eff = sub_q ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
  end

  fourBit_FA u_fa (
    .a_i    (a_nib),
    .b_i    (b_eff),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every _d gets a hold default first, so no path through this block leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub;  // a - b == a + ~b + 1
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = fa_s;
        carry_d             = fa_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = fa_cout;
          ovf_d   = ~(a_nib[3] ^ b_eff[3]) & (fa_s[3] ^ a_nib[3]);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand latches, loaded only on an accepted start.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are deliberately not reset; they are always reloaded before use, so a reset would only add fan-out.
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

  // Status is decoded from state; results come straight from registers.
  always_comb begin
    bus.busy     = (state_q == S_RUN);
    bus.done     = (state_q == S_DONE);
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.overflow = ovf_q;
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed scenarios plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    longint      ua, ub, r, sa, sb, sr;
    logic [63:0] rr;
    bit          c, v;
    ua = longint'(a);
    ub = longint'(b);
    r  = sub ? ua - ub : ua + ub;
    rr = r;
    c  = sub ? (ua >= ub) : (r >= (longint'(1) << W));
    sa = (ua >= (longint'(1) << (W - 1))) ? ua - (longint'(1) << W) : ua;
    sb = (ub >= (longint'(1) << (W - 1))) ? ub - (longint'(1) << W) : ub;
    sr = sub ? sa - sb : sa + sb;
    v  = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
    return {v, c, rr[W-1:0]};
  endfunction

  // Wait for done with a cycle budget; optionally scramble inputs while running.
  task automatic wait_done(input bit garbage, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 4 * NIBBLES + 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        cycles = i;
        check("busy_with_done", bus.busy, 1'b0);
        break;
      end
      check("busy_in_run", bus.busy, 1'b1);
      if (garbage) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    logic [W+1:0] exp;
    exp = model(a, b, sub);
    check({tag, "_sum"},  bus.sum,      exp[W-1:0]);
    check({tag, "_cout"}, bus.cout,     exp[W]);
    check({tag, "_ovf"},  bus.overflow, exp[W+1]);
  endtask

  // One complete operation starting just after a rising edge.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sub, input bit garbage);
    int cyc;
    bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(garbage, cyc);
    bus.start = 1'b0;
    check({tag, "_latency"}, cyc, NIBBLES);
    check_result(tag, a, b, sub);
  endtask

  // Idle with start low; results must hold and status must stay low.
  task automatic hold(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    logic [W+1:0] exp;
    exp = model(a, b, sub);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("hold", {bus.busy, bus.done, bus.overflow, bus.cout, bus.sum}, {2'b00, exp});
    end
  endtask

  initial begin
    int cyc;
    logic [W-1:0] ra, rb;
    bit           rs;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {bus.busy, bus.done, bus.overflow, bus.cout, bus.sum}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic cases.
    do_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    hold(10, 16'h1234, 16'h0FFF, 1'b0);
    do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
    hold(10, 16'hFFFF, 16'h0001, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
    hold(10, 16'h7FFF, 16'h0001, 1'b0);
    do_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0);
    hold(10, 16'h8000, 16'h0001, 1'b1);
    do_op("sub_neg",   16'h0003, 16'h0005, 1'b1, 1'b0);
    hold(10, 16'h0003, 16'h0005, 1'b1);

    // Back-to-back: start held high, new operands presented in DONE.
    bus.a = 16'h0001; bus.b = 16'h0001; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0, cyc);
    check("b2b_first_latency", cyc, NIBBLES);
    check_result("b2b_first", 16'h0001, 16'h0001, 1'b0);
    bus.a = 16'h0002; bus.b = 16'h0002;
    wait_done(1'b0, cyc);
    check("b2b_done_spacing", cyc, NIBBLES + 1);
    check_result("b2b_second", 16'h0002, 16'h0002, 1'b0);
    bus.start = 1'b0;
    hold(10, 16'h0002, 16'h0002, 1'b0);

    // Ignored start pulses and operand changes while running.
    do_op("run_noise", 16'h4321, 16'h1111, 1'b1, 1'b1);
    hold(10, 16'h4321, 16'h1111, 1'b1);

    // Reset on the second RUN cycle aborts the operation.
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_reset", {bus.busy, bus.done, bus.overflow, bus.cout, bus.sum}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {bus.busy, bus.done}, 2'b00);
    do_op("after_abort", 16'h0010, 16'h0020, 1'b0, 1'b0);
    hold(10, 16'h0010, 16'h0020, 1'b0);

    // Randomized operations with input noise during RUN.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ra;
      do_op("rand", ra, rb, rs, 1'($urandom_range(0, 1)));
      hold($urandom_range(1, 3), ra, rb, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
